// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// XLEN / RFIDX_WIDTH / RFREG_NUM mirror the values in xgriscv_defines.v.
package rf_wb_arbiter_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned RFIDX_WIDTH = 5;
   localparam int unsigned RFREG_NUM   = 32;

   typedef logic [RFIDX_WIDTH-1:0] rfidx_t;
   typedef logic [XLEN-1:0]        xdata_t;
   typedef logic [RFREG_NUM-1:0]   rfmask_t;

   // Which source loads the output register this cycle
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_A    = 2'd1,
      SRC_B    = 2'd2
   } wb_src_e;

   // One-hot decode of a destination register; x0 never appears in the mask
   function automatic rfmask_t idx_decode(input rfidx_t idx);
      rfmask_t m;
      m = '0;
      if (idx != '0) m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer-side handshakes and register-file write port of the arbiter.
interface rf_wb_arbiter_if;
   import rf_wb_arbiter_pkg::*;

   logic    a_valid;
   logic    a_ready;
   rfidx_t  a_idx;
   xdata_t  a_data;

   logic    b_valid;
   logic    b_ready;
   rfidx_t  b_idx;
   xdata_t  b_data;

   logic    we3;
   rfidx_t  wa3;
   xdata_t  wd3;
   rfmask_t pend_mask;

   // Producers / register file / issue logic side
   modport master (
      output a_valid, a_idx, a_data, b_valid, b_idx, b_data,
      input  a_ready, b_ready, we3, wa3, wd3, pend_mask
   );

   // Arbiter side
   modport slave (
      input  a_valid, a_idx, a_data, b_valid, b_idx, b_data,
      output a_ready, b_ready, we3, wa3, wd3, pend_mask
   );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// In-order FIFO for long-latency (port B) results. No bypass; exposes a
// per-entry valid/idx view so the top can build the pending-write mask.
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  rfidx_t                 push_idx_i,
   input  xdata_t                 push_data_i,
   input  logic                   pop_i,
   output logic                   full_o,
   output logic                   empty_o,
   output rfidx_t                 head_idx_o,
   output xdata_t                 head_data_o,
   output logic   [DEPTH-1:0]     ent_vld_o,
   output rfidx_t [DEPTH-1:0]     ent_idx_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   rfidx_t [DEPTH-1:0] idx_q;
   xdata_t [DEPTH-1:0] data_q;
   logic              do_push, do_pop;

   assign full_o      = (cnt_q == CW'(DEPTH));
   assign empty_o     = (cnt_q == '0);
   assign do_push     = push_i && !full_o;
   assign do_pop      = pop_i && !empty_o;
   assign head_idx_o  = idx_q[rd_q];
   assign head_data_o = data_q[rd_q];
   assign ent_vld_o   = vld_q;
   assign ent_idx_o   = idx_q;

   // Pointer, count and per-entry valid next state; pointers wrap modulo DEPTH
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      vld_d = vld_q;
      if (do_push) begin
         wr_d         = wr_q + PW'(1);
         vld_d[wr_q]  = 1'b1;
      end
      if (do_pop) begin
         rd_d         = rd_q + PW'(1);
         vld_d[rd_q]  = 1'b0;
      end
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Entry storage; contents are qualified by vld_q so no reset is needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         idx_q[wr_q]  <= push_idx_i;
         data_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register-file write port: merges the in-order
// pipeline (A) with queued long-latency results (B) and publishes the
// pending-write mask of queued B destinations.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   rf_wb_arbiter_if.slave bus
);

   logic                 fifo_full, fifo_empty;
   rfidx_t               head_idx;
   xdata_t               head_data;
   logic   [DEPTH-1:0]   ent_vld;
   rfidx_t [DEPTH-1:0]   ent_idx;

   logic    a_rdy, b_rdy, a_acc, push, pop;
   wb_src_e src;
   logic    starve_q, starve_d;
   logic    we3_q, we3_d;
   logic    outb_q, outb_d;
   rfidx_t  wa3_q, wa3_d;
   xdata_t  wd3_q, wd3_d;
   rfmask_t pend;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_idx_i  (bus.b_idx),
      .push_data_i (bus.b_data),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_idx_o  (head_idx),
      .head_data_o (head_data),
      .ent_vld_o   (ent_vld),
      .ent_idx_o   (ent_idx)
   );

   // Readies from registered state only, source selection and output-register next state
   always_comb begin
      a_rdy    = !reset && !(fifo_full && !starve_q);
      b_rdy    = !reset && !fifo_full;
      a_acc    = bus.a_valid && a_rdy;
      push     = bus.b_valid && b_rdy;
      src      = SRC_NONE;
      we3_d    = 1'b0;
      outb_d   = 1'b0;
      wa3_d    = wa3_q;
      wd3_d    = wd3_q;
      starve_d = bus.a_valid && !a_acc;

      if (reset)                        src = SRC_NONE;
      else if (starve_q && bus.a_valid) src = SRC_A;
      else if (fifo_full)               src = SRC_B;
      else if (bus.a_valid)             src = SRC_A;
      else if (!fifo_empty)             src = SRC_B;

      pop = (src == SRC_B);

      case (src)
         SRC_A: begin
            we3_d = (bus.a_idx != '0);
            wa3_d = bus.a_idx;
            wd3_d = bus.a_data;
         end
         SRC_B: begin
            we3_d  = (head_idx != '0);
            outb_d = (head_idx != '0);
            wa3_d  = head_idx;
            wd3_d  = head_data;
         end
         default: ;
      endcase
   end

   // Output register and starvation flag
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= 1'b0;
         we3_q    <= 1'b0;
         outb_q   <= 1'b0;
         wa3_q    <= '0;
         wd3_q    <= '0;
      end else begin
         starve_q <= starve_d;
         we3_q    <= we3_d;
         outb_q   <= outb_d;
         wa3_q    <= wa3_d;
         wd3_q    <= wd3_d;
      end
   end

   // Pending mask: every queued B destination plus a B write held in the output register
   always_comb begin
      pend = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pend = pend | idx_decode(ent_idx[i]);
      end
      if (outb_q) pend = pend | idx_decode(wa3_q);
   end

   // we3 and pend_mask are masked while reset is high so that a beat accepted
   // just before reset never reaches the register file's negedge capture.
   assign bus.a_ready   = a_rdy;
   assign bus.b_ready   = b_rdy;
   assign bus.we3       = we3_q && !reset;
   assign bus.wa3       = wa3_q;
   assign bus.wd3       = wd3_q;
   assign bus.pend_mask = reset ? '0 : pend;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that drives the single write port (`we3`/`wa3`/`wd3`) of the integer register file. It merges two producers: the in-order pipeline write-back (port A) and a long-latency unit such as load/mul/div (port B). Port B results pass through a small in-order FIFO. The block exports a pending-write mask so the issue logic can stall on RAW and WAW hazards against queued B results.

## Interface
- `DEPTH`, 4: B-side FIFO entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `a_valid`  in  1  port A write request
- `a_ready`  out  1  port A accepted when `a_valid && a_ready`
- `a_idx`  in  `RFIDX_WIDTH`  destination register
- `a_data`  in  `XLEN`  write data
- `b_valid`, `b_ready`, `b_idx`, `b_data`: same as port A, for port B
- `we3`  out  1  register-file write enable (registered)
- `wa3`  out  `RFIDX_WIDTH`  register-file write address (registered)
- `wd3`  out  `XLEN`  register-file write data (registered)
- `pend_mask`  out  `RFREG_NUM`  bit r=1 while a B write to r is queued or sitting in the output register

## Operation
- **Port B acceptance**
  - Accepted entries push to the FIFO tail.
  - `b_ready = !full`, computed from registered count only. There is no combinational `b_valid`→`b_ready` path.
  - Push and pop may occur in the same cycle.
- **Port A path**
  - Port A is never buffered.
  - When A is granted, the accepted beat goes straight to the output register.
- **Selection** (each cycle; exactly one source may load the output register):
  1. `starve` set → A wins if `a_valid`.
  2. FIFO full → FIFO head wins, `a_ready=0`, and `starve` is set for the next cycle if `a_valid`.
  3. `a_valid` → A wins; the FIFO holds.
  4. FIFO non-empty → FIFO head pops.
  5. Otherwise the output register loads `we3=0`.
- `starve` clears whenever A is accepted or `a_valid=0`. As a result, A waits at most one cycle under continuous B pressure.
- `a_ready = !(full && !starve)` (from registered state). `a_ready=0` and `b_ready=0` while `reset`.
- **x0 handling**
  - A handshake with `idx==0` completes normally but produces `we3=0`.
  - A B entry with `idx==0` is still pushed, to preserve ordering, but never sets `pend_mask` and pops with `we3=0`.
- **`pend_mask`**
  - Computed as the OR of the one-hot decode of every valid FIFO entry's idx, plus `wa3` when the output register holds a B write.
  - Bit 0 is always 0.
  - Multiple queued writes to the same register keep the bit set until the last one leaves the output register.
- **Ordering responsibility**
  - The arbiter never reorders B writes.
  - It does not guard WAW between A and B. Issue logic must not send A to r while `pend_mask[r]`.

## Timing
- **Reset values:** `we3=0`, `wa3=0`, `wd3=0`, `pend_mask=0`, FIFO empty, `starve=0`. `a_ready=1` and `b_ready=1` in the first cycle after reset deasserts.
- **Reset mid-operation:** all queued writes and the output register are discarded. No `we3` pulse follows reset.
- **A latency:** handshake in cycle n → `we3/wa3/wd3` valid throughout cycle n+1. The register file captures on the negedge inside n+1, so its combinational reads show the new value from the second half of n+1.
- **B latency:** push in cycle n → earliest `we3` in cycle n+2 (FIFO has no bypass).
- `pend_mask` rises in cycle n+1 after the B push and falls in the cycle after that entry's `we3` cycle.
- **Throughput:** one register-file write per cycle, sustained.
- **Full boundary:** push to the last free slot makes `b_ready=0` the next cycle. Pop while full with simultaneous push is impossible, because `b_ready=0`.
- **Pointer rules:** pointers wrap modulo `DEPTH`. Count width is clog2(`DEPTH`)+1.

## Structure
- `XLEN`, `RFIDX_WIDTH` and `RFREG_NUM` come from xgriscv_defines.v.
- No new shared constants are needed. `DEPTH` stays a local parameter.
- One sub-module, `wb_fifo`: a synchronous FIFO with push/pop, full/empty, count and a per-entry valid/idx view for the `pend_mask` decode.
- Arbitration, the `starve` flag and the output register live in the top module.

## Test plan
- **Reset:** A push `x5=0x11` then assert `reset` the next cycle → no `we3` pulse, `pend_mask=0`, both readys=1 after release.
- **A only:** back-to-back A writes `x1=0xA`, `x2=0xB` in cycles 0,1 → `we3=1` in cycles 1,2 with `wa3`=1,2, `wd3`=0xA,0xB.
- **B only:** B push `x7=0xDEAD` in cycle 0 → `pend_mask[7]=1` in cycle 1, `we3` with `wa3=7` in cycle 2, `pend_mask[7]=0` in cycle 3.
- **Fill, starvation, ordering:** four B pushes `x3..x6` with A idle, then both valid every cycle with A `x9` → `b_ready=0` when full, head drains first, A `x9` written at most 2 cycles after its `a_valid` rose, B writes emerge in order `x3,x4,x5,x6`.
- **x0 handling:** A `x0=0x1` and B `x0=0x2` → both handshakes complete, `we3` never asserted, `pend_mask[0]` stays 0.
- **Duplicate destination:** B pushes `x8=1` then `x8=2` → `pend_mask[8]` stays 1 until the second write leaves, final `wd3` to `x8` is 2.
